// File: rtl/div_hilo_unit.sv
// div_hilo_unit: multi-cycle wrapper around an external combinational unsigned
// divider. It captures operand magnitudes, holds them for DIV_CYCLES edges,
// sign-corrects the result and commits it to HI/LO. It also owns MTHI/MTLO.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accepts start and MTHI/MTLO writes; div_a/div_b hold last values
// RUN   | divider settling window; cnt counts down, commit when cnt==0
module div_hilo_unit #(
  parameter int WIDTH      = 16,
  parameter int DIV_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(DIV_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] div_a_q, div_a_d;
  logic [WIDTH-1:0] div_b_q, div_b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  // Two's complement negate, modulo 2^WIDTH (so -0x8000 stays 0x8000).
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  // Next-state, capture, countdown and commit logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_a_d = div_a_q;
    div_b_d = div_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // MT writes land first; a same-cycle divide overwrites them at commit.
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          state_d = RUN;
          div_a_d = (op_signed && op_a[WIDTH-1]) ? negate(op_a) : op_a;
          div_b_d = (op_signed && op_b[WIDTH-1]) ? negate(op_b) : op_b;
          q_neg_d = op_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          r_neg_d = op_signed && op_a[WIDTH-1];
          zero_d  = (op_b == '0);
          cnt_d   = CNT_INIT;
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // A zero divisor leaves HI/LO untouched; only the flag reports it.
          if (!zero_q) begin
            lo_d = q_neg_q ? negate(div_q) : div_q;
            hi_d = r_neg_q ? negate(div_r) : div_r;
          end
          done_d  = 1'b1;
          dbz_d   = zero_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_a_q <= '0;
      div_b_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign div_a       = div_a_q;
  assign div_b       = div_b_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_div_hilo_unit.sv
// Directed bench for div_hilo_unit (WIDTH=16, DIV_CYCLES=4). The external
// divider is emulated combinationally; a zero divisor returns junk so that a
// commit which should have been skipped shows up in HI/LO.
module tb_div_hilo_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op_signed;
  logic [15:0] op_a, op_b;
  logic        hi_we, lo_we;
  logic [15:0] wdata;
  logic [15:0] div_a, div_b, div_q, div_r;
  logic        busy, done, div_by_zero;
  logic [15:0] hi, lo;

  int errors = 0;
  int checks = 0;

  div_hilo_unit #(.WIDTH(16), .DIV_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op_signed(op_signed),
    .op_a(op_a), .op_b(op_b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .div_a(div_a), .div_b(div_b), .div_q(div_q), .div_r(div_r),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  assign div_q = (div_b == 16'd0) ? 16'hDEAD : div_a / div_b;
  assign div_r = (div_b == 16'd0) ? 16'hBEEF : div_a % div_b;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive start for one cycle; returns at the falling edge after E0.
  task automatic issue(input logic s, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    start = 1'b1; op_signed = s; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // From the falling edge after E0: busy for E1..E3, done after E4 only.
  task automatic finish_check(input string tag, input logic [15:0] exp_lo,
                              input logic [15:0] exp_hi, input logic exp_dbz);
    chk({tag, "_busy_e0"}, {15'd0, busy}, 16'd1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk({tag, "_busy_run"}, {14'd0, busy, done}, 16'b10);
    end
    @(negedge clk);
    chk({tag, "_done"}, {14'd0, busy, done}, 16'b01);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_dbz"}, {15'd0, div_by_zero}, {15'd0, exp_dbz});
  endtask

  initial begin
    logic seen_done;
    rst = 1'b1; start = 1'b0; op_signed = 1'b0; op_a = '0; op_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {14'd0, done, div_by_zero}, 16'd0);
    chk("rst_hi", hi, 16'd0);
    chk("rst_lo", lo, 16'd0);
    chk("rst_div_a", div_a, 16'd0);
    chk("rst_div_b", div_b, 16'd0);

    // DIVU 100/7
    issue(1'b0, 16'd100, 16'd7);
    chk("t1_div_a", div_a, 16'd100);
    chk("t1_div_b", div_b, 16'd7);
    finish_check("t1", 16'd14, 16'd2, 1'b0);
    @(negedge clk);
    chk("t1_done_once", {14'd0, done, div_by_zero}, 16'd0);
    chk("t1_hold_div_a", div_a, 16'd100);

    // DIV -7/2 and 7/-2
    issue(1'b1, 16'hFFF9, 16'd2);
    chk("t2a_div_a", div_a, 16'd7);
    chk("t2a_div_b", div_b, 16'd2);
    finish_check("t2a", 16'hFFFD, 16'hFFFF, 1'b0);
    issue(1'b1, 16'd7, 16'hFFFE);
    chk("t2b_div_b", div_b, 16'd2);
    finish_check("t2b", 16'hFFFD, 16'h0001, 1'b0);

    // DIV 0x8000 / -1 wraps
    issue(1'b1, 16'h8000, 16'hFFFF);
    chk("t3_div_a", div_a, 16'h8000);
    chk("t3_div_b", div_b, 16'h0001);
    finish_check("t3", 16'h8000, 16'h0000, 1'b0);

    // MTHI / MTLO then DIVU 5/0
    @(negedge clk);
    hi_we = 1'b1; wdata = 16'h1234;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 16'h5678;
    @(negedge clk);
    lo_we = 1'b0;
    chk("t4_mthi", hi, 16'h1234);
    chk("t4_mtlo", lo, 16'h5678);
    issue(1'b0, 16'd5, 16'd0);
    finish_check("t4", 16'h5678, 16'h1234, 1'b1);
    @(negedge clk);
    chk("t4_dbz_once", {15'd0, div_by_zero}, 16'd0);

    // start and hi_we during RUN are dropped; start in done cycle is taken
    issue(1'b0, 16'd100, 16'd7);
    start = 1'b1; op_a = 16'd9; op_b = 16'd3; hi_we = 1'b1; wdata = 16'hAAAA;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    chk("t5_ign_div_a", div_a, 16'd100);
    chk("t5_ign_hi", hi, 16'h1234);
    repeat (2) @(negedge clk);
    chk("t5_still_busy", {15'd0, busy}, 16'd1);
    @(negedge clk);
    chk("t5_done", {15'd0, done}, 16'd1);
    chk("t5_lo", lo, 16'd14);
    chk("t5_hi", hi, 16'd2);
    start = 1'b1; op_signed = 1'b0; op_a = 16'd9; op_b = 16'd3;
    @(negedge clk);
    start = 1'b0;
    chk("t5_b2b_div_a", div_a, 16'd9);
    chk("t5_b2b_div_b", div_b, 16'd3);
    finish_check("t5b", 16'd3, 16'd0, 1'b0);

    // reset in the second RUN cycle
    issue(1'b0, 16'd100, 16'd7);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_busy", {15'd0, busy}, 16'd0);
    chk("t6_hi", hi, 16'd0);
    chk("t6_lo", lo, 16'd0);
    chk("t6_div_a", div_a, 16'd0);
    seen_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("t6_no_done", {15'd0, seen_done}, 16'd0);
    issue(1'b0, 16'd20, 16'd6);
    finish_check("t6", 16'd3, 16'd2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
